truth_table_sweeper: RTL

//  - Sequencer for a 4-input combinational function block f(A,B,C,D).
//  - On start, drives all 16 input vectors in ascending order {A,B,C,D} = 0..15.
//  - Holds each vector for a settle window, then samples f.
//  - Assembles a 16-bit truth table and compares it against an expected table.
//  - Sits between a lab-top controller and the function block. Replaces hand-timed stimulus sequences.

---
 rtl/sweep_pkg.sv | 16 +
 rtl/sweep_settle_timer.sv | 44 ++++
 rtl/truth_table_sweeper.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/sweep_pkg.sv
// Shared definitions for the truth-table sweeper: state encoding and
// vector/counter dimensions.
package sweep_pkg;

    localparam int NUM_VEC = 16;
    localparam int VEC_W   = 4;
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } sweep_state_e;

endpackage

// File: rtl/sweep_settle_timer.sv
// Settle-window counter: clears to 0, counts up while enabled, and flags
// terminal count when the count equals SETTLE.
module sweep_settle_timer
    import sweep_pkg::*;
#(
    parameter int unsigned SETTLE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    if (SETTLE > 15) begin : g_settle_range
        $error("sweep_settle_timer: SETTLE must be in 0..15");
    end

    localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear has priority over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == SETTLE_C);

endmodule

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: steps {A,B,C,D} through 0..15, holds each vector
// SETTLE+1 cycles, samples f_in in a following SAMPLE cycle, then compares
// the captured table against 'expected' in a one-cycle FINISH state.
// Optional macro SWEEP_ERRIDX_EN adds fail_idx/fail_any (lowest mismatch).
// start is a single-cycle request, honoured only in IDLE; there is no
// back-pressure and no queuing of requests made while busy or finishing.
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int unsigned SETTLE = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [NUM_VEC-1:0] expected,
    input  logic               f_in,
    output logic               A,
    output logic               B,
    output logic               C,
    output logic               D,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [NUM_VEC-1:0] table_out,
`ifdef SWEEP_ERRIDX_EN
    output logic [VEC_W-1:0]   fail_idx,
    output logic               fail_any,
`endif
    output sweep_state_e       state_dbg
);

    sweep_state_e       state_q, state_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [NUM_VEC-1:0] table_q, table_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               tmr_clr, tmr_en, tmr_tc;

`ifdef SWEEP_ERRIDX_EN
    logic [VEC_W-1:0]   fidx_q, fidx_d;
    logic               fany_q, fany_d;
    logic [NUM_VEC-1:0] mism;
    logic [VEC_W-1:0]   low_idx;

    // Priority encoder: lowest index where the captured table disagrees.
    always_comb begin
        mism    = table_q ^ expected;
        low_idx = '0;
        for (int i = NUM_VEC - 1; i >= 0; i--) begin
            if (mism[i]) begin
                low_idx = VEC_W'(i);
            end
        end
    end
`endif

    sweep_settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr_i (tmr_clr),
        .en_i  (tmr_en),
        .tc_o  (tmr_tc)
    );

    // Next-state and datapath updates for the sweep sequencer.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        table_d = table_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;
`ifdef SWEEP_ERRIDX_EN
        fidx_d  = fidx_q;
        fany_d  = fany_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = HOLD;
                    vec_d   = '0;
                    table_d = '0;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    tmr_clr = 1'b1;
                end
            end
            HOLD: begin
                if (tmr_tc) begin
                    state_d = SAMPLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            SAMPLE: begin
                table_d[vec_q] = f_in;
                tmr_clr        = 1'b1;
                if (vec_q != VEC_W'(NUM_VEC - 1)) begin
                    vec_d   = vec_q + 1'b1;
                    state_d = HOLD;
                end else begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                pass_d  = (table_q == expected);
                state_d = IDLE;
`ifdef SWEEP_ERRIDX_EN
                fidx_d  = low_idx;
                fany_d  = |mism;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any sweep without done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            table_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
`ifdef SWEEP_ERRIDX_EN
            fidx_q  <= '0;
            fany_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            table_q <= table_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
`ifdef SWEEP_ERRIDX_EN
            fidx_q  <= fidx_d;
            fany_q  <= fany_d;
`endif
        end
    end

    assign {A, B, C, D} = vec_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign table_out    = table_q;
    assign state_dbg    = state_q;
`ifdef SWEEP_ERRIDX_EN
    assign fail_idx     = fidx_q;
    assign fail_any     = fany_q;
`endif

endmodule
